aoi22_bist_ctrl: RTL and testbench
==================================

# aoi22_bist_ctrl

Built-in self-test sequencer for the 9-track 5 V AOI22 cell (ZN = ~((A1&A2)|(B1&B2))). It sits on both sides of the cell under test. Upstream, it drives the cell's A1/A2/B1/B2 inputs with an exhaustive 16-pattern sweep. Downstream, it consumes ZN, compares each sample against a golden AOI22 function, counts mismatches and compacts the response into a 16-bit MISR signature.

## Interface
- PASSES, default 1: number of full 16-pattern sweeps per run; legal range 1..255.
- SETTLE, default 2: extra hold cycles per pattern before ZN is sampled; legal range 0..15.
- SEED, default 16'hFFFF: MISR value loaded at reset and at run start.

Ports (all synchronous to CLK):
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  run request; sampled only in IDLE or DONE.
- ZN  input  1  output of the cell under test.
- A1, A2, B1, B2  output  1 each  registered stimulus to the cell under test.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  high from run completion until the next START or RST.
- PASS  output  1  valid when DONE=1; equals (FAIL_CNT == 0).
- FAIL_CNT  output  8  count of mismatching samples; saturates at 255.
- FIRST_FAIL  output  4  pattern index of the first mismatch in the run.
- SIG  output  16  MISR signature.

## Operation
- FSM states:
  - IDLE: entered on RST.
  - RUN: entered when START=1 in IDLE or DONE.
  - DONE: entered when the final sample of the final pass has been taken. Leaves for RUN on START=1.
- START is ignored while in RUN.
- Run start clears the following: pattern counter PAT[3:0]=0, pass counter=0, settle counter=0, FAIL_CNT=0, FIRST_FAIL=0. SIG is loaded with SEED.
- Stimulus mapping: A1=PAT[3], A2=PAT[2], B1=PAT[1], B2=PAT[0]. Stimulus outputs are 0 in IDLE and DONE.
- Per pattern:
  - The settle counter counts 0..SETTLE.
  - When it equals SETTLE, ZN is sampled and compared with the golden value ~((PAT[3]&PAT[2])|(PAT[1]&PAT[0])).
  - PAT then increments and the settle counter returns to 0.
- PAT wraps from 15 to 0 and increments the pass counter. The wrap after pass PASSES-1 moves the FSM to DONE instead.
- Mismatch definition: ZN !== golden, so X or Z on ZN counts as a mismatch.
- On a mismatch:
  - FAIL_CNT increments, but holds at 255.
  - If FAIL_CNT was 0, FIRST_FAIL takes PAT.
- MISR update on every sample:
  - fb = SIG[15] ^ ZN.
  - SIG <= {SIG[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
  - A non-0/1 ZN value is folded in as 1.
- In DONE: FAIL_CNT, FIRST_FAIL, SIG and PASS hold their values.
- RST (any state, including mid-run) returns the block to IDLE with:
  - all outputs 0, except SIG=SEED;
  - all counters 0.

## Timing
- Reset values: A1=A2=B1=B2=0, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, FIRST_FAIL=0, SIG=SEED.
- Run start: on the edge that samples START=1, BUSY=1 and pattern 0 appear on the stimulus outputs in the following cycle.
- Each pattern is held for exactly SETTLE+1 cycles. ZN is sampled at the edge that ends the last of those cycles.
- Run length: BUSY is high for exactly 16·PASSES·(SETTLE+1) cycles.
- Completion: DONE, PASS and the final SIG and FAIL_CNT are visible in the cycle after the last sampling edge. BUSY falls in that same cycle.
- Restart from DONE: START=1 gives BUSY=1 and DONE=0 in the next cycle. There are no idle bubbles.
- RST wins over START when both are asserted on the same edge.

## Test plan
- Ideal AOI22 model on ZN, PASSES=1, SETTLE=2, one-cycle START pulse -> BUSY for 48 cycles, then DONE=1, PASS=1, FAIL_CNT=0, FIRST_FAIL=0.
- ZN stuck-at-0, PASSES=2 -> golden is 1 on 9 patterns (0,1,2,4,5,6,8,9,10), so FAIL_CNT=18, FIRST_FAIL=0, PASS=0.
- ZN stuck-at-1, PASSES=1, SETTLE=0 -> FAIL_CNT=7, FIRST_FAIL=3, BUSY for 16 cycles.
- ZN stuck-at-0, PASSES=40 -> raw count would be 360; FAIL_CNT saturates and holds at 255, PASS=0.
- RST asserted mid-run at pattern 7 -> next cycle all outputs at reset values, SIG=SEED. START pulses during RUN change nothing, and BUSY duration is unaffected.
- Two back-to-back runs with the ideal model, restarted from DONE -> identical SIG both times, with 0 idle cycles between runs. A third run that inverts ZN on pattern 12 only -> FAIL_CNT=1, FIRST_FAIL=12, SIG differs from the clean value.

Source files
------------

// File: rtl/aoi22_bist_ctrl.sv
// Exhaustive BIST sequencer for an AOI22 cell: drives all 16 input patterns,
// checks ZN against the ideal function, counts failures and builds a MISR signature.
module aoi22_bist_ctrl #(
    parameter int          PASSES = 1,
    parameter int          SETTLE = 2,
    parameter logic [15:0] SEED   = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ZN,
    output logic        A1,
    output logic        A2,
    output logic        B1,
    output logic        B2,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  FAIL_CNT,
    output logic [3:0]  FIRST_FAIL,
    output logic [15:0] SIG
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [3:0]  SETTLE_L  = 4'(SETTLE);
    localparam logic [7:0]  LAST_PASS = 8'(PASSES - 1);
    localparam logic [15:0] MISR_POLY = 16'h1021;

    state_t      state_reg, state_next;
    logic [3:0]  pat_reg, pat_next;
    logic [7:0]  pass_reg, pass_next;
    logic [3:0]  settle_reg, settle_next;
    logic [7:0]  fail_reg, fail_next;
    logic [3:0]  first_reg, first_next;
    logic [15:0] sig_reg, sig_next;
    logic [3:0]  stim_reg, stim_next;

    logic golden;
    logic mismatch;
    logic zn_bit;
    logic fb;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            pat_reg    <= 4'd0;
            pass_reg   <= 8'd0;
            settle_reg <= 4'd0;
            fail_reg   <= 8'd0;
            first_reg  <= 4'd0;
            sig_reg    <= SEED;
            stim_reg   <= 4'd0;
        end else begin
            state_reg  <= state_next;
            pat_reg    <= pat_next;
            pass_reg   <= pass_next;
            settle_reg <= settle_next;
            fail_reg   <= fail_next;
            first_reg  <= first_next;
            sig_reg    <= sig_next;
            stim_reg   <= stim_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pat_next    = pat_reg;
        pass_next   = pass_reg;
        settle_next = settle_reg;
        fail_next   = fail_reg;
        first_next  = first_reg;
        sig_next    = sig_reg;

        golden   = ~((pat_reg[3] & pat_reg[2]) | (pat_reg[1] & pat_reg[0]));
        // Four-state compare so an X/Z on ZN is always a miscompare.
        mismatch = (ZN !== golden);
        zn_bit   = (ZN === 1'b0) ? 1'b0 : 1'b1;
        fb       = sig_reg[15] ^ zn_bit;

        case (state_reg)
            ST_RUN: begin
                if (settle_reg == SETTLE_L) begin
                    sig_next = {sig_reg[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
                    if (mismatch) begin
                        if (fail_reg != 8'hFF) fail_next = fail_reg + 8'd1;
                        if (fail_reg == 8'd0)  first_next = pat_reg;
                    end
                    settle_next = 4'd0;
                    pat_next    = pat_reg + 4'd1;
                    if (pat_reg == 4'hF) begin
                        if (pass_reg == LAST_PASS) state_next = ST_DONE;
                        else                       pass_next  = pass_reg + 8'd1;
                    end
                end else begin
                    settle_next = settle_reg + 4'd1;
                end
            end
            default: begin
                if (START) begin
                    state_next  = ST_RUN;
                    pat_next    = 4'd0;
                    pass_next   = 8'd0;
                    settle_next = 4'd0;
                    fail_next   = 8'd0;
                    first_next  = 4'd0;
                    sig_next    = SEED;
                end
            end
        endcase

        // Stimulus is registered from the next-state view so it lines up with BUSY.
        stim_next = (state_next == ST_RUN) ? pat_next : 4'd0;
    end

    assign {A1, A2, B1, B2} = stim_reg;
    assign BUSY       = (state_reg == ST_RUN);
    assign DONE       = (state_reg == ST_DONE);
    assign PASS       = (state_reg == ST_DONE) && (fail_reg == 8'd0);
    assign FAIL_CNT   = fail_reg;
    assign FIRST_FAIL = first_reg;
    assign SIG        = sig_reg;

endmodule

// File: tb/tb_aoi22_bist_ctrl.sv
// Directed bench: four sequencer instances with different sweep settings,
// each driven by a behavioural cell model (ideal, pattern-12 fault, stuck-at).
module tb_aoi22_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int P_PASSES [4] = '{1, 2, 1, 40};
    localparam int P_SETTLE [4] = '{2, 2, 0, 0};

    logic             rst;
    logic [3:0]       start;
    logic [3:0]       busy, done, pass;
    logic [3:0][3:0]  stim;
    logic [3:0][7:0]  fail_cnt;
    logic [3:0][3:0]  first_fail;
    logic [3:0][15:0] sig;
    logic [3:0][1:0]  zn_mode;   // 0 ideal, 1 invert on pattern 12, 2 stuck-0, 3 stuck-1

    int n_checks = 0;
    int n_pass   = 0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            logic a1, a2, b1, b2, zn, busy_l, done_l, pass_l;
            logic [7:0]  fail_l;
            logic [3:0]  first_l;
            logic [15:0] sig_l;

            assign zn = (zn_mode[gi] == 2'd2) ? 1'b0 :
                        (zn_mode[gi] == 2'd3) ? 1'b1 :
                        (~((a1 & a2) | (b1 & b2)) ^
                         ((zn_mode[gi] == 2'd1) && ({a1, a2, b1, b2} == 4'd12)));

            aoi22_bist_ctrl #(
                .PASSES (P_PASSES[gi]),
                .SETTLE (P_SETTLE[gi]),
                .SEED   (16'hFFFF)
            ) u_dut (
                .CLK        (clk),
                .RST        (rst),
                .START      (start[gi]),
                .ZN         (zn),
                .A1         (a1),
                .A2         (a2),
                .B1         (b1),
                .B2         (b2),
                .BUSY       (busy_l),
                .DONE       (done_l),
                .PASS       (pass_l),
                .FAIL_CNT   (fail_l),
                .FIRST_FAIL (first_l),
                .SIG        (sig_l)
            );

            assign stim[gi]       = {a1, a2, b1, b2};
            assign busy[gi]       = busy_l;
            assign done[gi]       = done_l;
            assign pass[gi]       = pass_l;
            assign fail_cnt[gi]   = fail_l;
            assign first_fail[gi] = first_l;
            assign sig[gi]        = sig_l;
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Signature of one clean 16-pattern sweep from SEED, optionally with ZN flipped on pattern 12.
    function automatic logic [15:0] misr_model(input bit inv12);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int p = 0; p < 16; p++) begin
            logic [3:0] pv;
            logic g, fbk;
            pv  = p[3:0];
            g   = ~((pv[3] & pv[2]) | (pv[1] & pv[0]));
            if (inv12 && pv == 4'd12) g = ~g;
            fbk = s[15] ^ g;
            s   = {s[14:0], 1'b0} ^ (fbk ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    // Pulse START for instance i and count BUSY cycles (bounded).
    task automatic run(input int i, input bit poke, output int cyc,
                       output logic fb, output logic fd, output logic [3:0] s3);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        fb  = busy[i];
        fd  = done[i];
        cyc = 0;
        s3  = 4'd0;
        while (busy[i] && cyc < 5000) begin
            if (cyc == 3) s3 = stim[i];
            start[i] = poke && (cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start[i] = 1'b0;
        $display("run dut%0d: busy=%0d done=%0d pass=%0d fail_cnt=%0d first=%0d sig=%h",
                 i, cyc, done[i], pass[i], fail_cnt[i], first_fail[i], sig[i]);
    endtask

    int          cyc;
    logic        fb, fd;
    logic [3:0]  s3;
    logic [15:0] clean_sig, inv_sig;

    initial begin
        rst       = 1'b1;
        start     = 4'd0;
        zn_mode   = '{2'd2, 2'd3, 2'd2, 2'd0};   // [3]..[0]
        clean_sig = misr_model(1'b0);
        inv_sig   = misr_model(1'b1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_stim%0d", i),  stim[i],       4'd0);
            check($sformatf("rst_busy%0d", i),  busy[i],       1'b0);
            check($sformatf("rst_done%0d", i),  done[i],       1'b0);
            check($sformatf("rst_pass%0d", i),  pass[i],       1'b0);
            check($sformatf("rst_fail%0d", i),  fail_cnt[i],   8'd0);
            check($sformatf("rst_first%0d", i), first_fail[i], 4'd0);
            check($sformatf("rst_sig%0d", i),   sig[i],        16'hFFFF);
        end
        rst = 1'b0;
        @(negedge clk);

        // Ideal cell, PASSES=1, SETTLE=2
        run(0, 1'b0, cyc, fb, fd, s3);
        check("r1_first_busy", fb, 1'b1);
        check("r1_first_done", fd, 1'b0);
        check("r1_stim_cyc3",  s3, 4'd1);
        check("r1_busy_len",   cyc, 48);
        check("r1_done",       done[0], 1'b1);
        check("r1_pass",       pass[0], 1'b1);
        check("r1_fail",       fail_cnt[0], 8'd0);
        check("r1_first",      first_fail[0], 4'd0);
        check("r1_sig",        sig[0], clean_sig);
        check("r1_stim_idle",  stim[0], 4'd0);

        // Immediate restart from DONE, with a START poke mid-run
        run(0, 1'b1, cyc, fb, fd, s3);
        check("r2_first_busy", fb, 1'b1);
        check("r2_first_done", fd, 1'b0);
        check("r2_busy_len",   cyc, 48);
        check("r2_pass",       pass[0], 1'b1);
        check("r2_sig",        sig[0], clean_sig);

        // Fault on pattern 12 only
        zn_mode[0] = 2'd1;
        run(0, 1'b0, cyc, fb, fd, s3);
        check("r3_first_busy", fb, 1'b1);
        check("r3_fail",       fail_cnt[0], 8'd1);
        check("r3_first",      first_fail[0], 4'd12);
        check("r3_pass",       pass[0], 1'b0);
        check("r3_sig",        sig[0], inv_sig);
        check("r3_sig_differs", (sig[0] != clean_sig), 1'b1);

        // Mid-run reset at pattern 7, with START asserted on the same edge
        zn_mode[0] = 2'd2;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        begin
            int k;
            k = 0;
            while (stim[0] != 4'd7 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("mr_reach_pat7", stim[0], 4'd7);
        check("mr_fail_pre",   fail_cnt[0], 8'd6);
        rst      = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        check("mr_busy",  busy[0], 1'b0);
        check("mr_done",  done[0], 1'b0);
        check("mr_pass",  pass[0], 1'b0);
        check("mr_stim",  stim[0], 4'd0);
        check("mr_fail",  fail_cnt[0], 8'd0);
        check("mr_first", first_fail[0], 4'd0);
        check("mr_sig",   sig[0], 16'hFFFF);
        rst      = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        check("mr_idle_busy", busy[0], 1'b0);

        // Stuck-at-0, PASSES=2
        run(1, 1'b0, cyc, fb, fd, s3);
        check("s0p2_busy_len", cyc, 96);
        check("s0p2_fail",     fail_cnt[1], 8'd18);
        check("s0p2_first",    first_fail[1], 4'd0);
        check("s0p2_pass",     pass[1], 1'b0);
        check("s0p2_done",     done[1], 1'b1);

        // Stuck-at-1, SETTLE=0
        run(2, 1'b0, cyc, fb, fd, s3);
        check("s1_busy_len", cyc, 16);
        check("s1_stim_cyc3", s3, 4'd3);
        check("s1_fail",     fail_cnt[2], 8'd7);
        check("s1_first",    first_fail[2], 4'd3);
        check("s1_pass",     pass[2], 1'b0);

        // Stuck-at-0, PASSES=40: count saturates
        run(3, 1'b0, cyc, fb, fd, s3);
        check("sat_busy_len", cyc, 640);
        check("sat_fail",     fail_cnt[3], 8'd255);
        check("sat_first",    first_fail[3], 4'd0);
        check("sat_pass",     pass[3], 1'b0);
        repeat (3) @(negedge clk);
        check("sat_hold",     fail_cnt[3], 8'd255);
        check("sat_done",     done[3], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
